// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch: PC, single-outstanding imem handshake, IF/ID register.
// Optional macro FETCH_NOP_BUBBLE_EN: id_instr reads addi x0,x0,0 whenever id_valid is low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_op,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7
);
`ifdef FETCH_NOP_BUBBLE_EN
    localparam bit BUBBLE_EN = 1'b1;
`else
    localparam bit BUBBLE_EN = 1'b0;
`endif
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RST_INSTR = BUBBLE_EN ? NOP_INSTR : 32'h0000_0000;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      r_state;
    logic        r_imem_req;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;

    logic        w_accept;
    logic        w_load_ok;
    logic [31:0] w_redirect_pc;

    assign w_accept      = r_imem_req & imem_ready;
    assign w_load_ok     = ~r_id_valid | ~stall;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_imem_req   <= 1'b0;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_skid_instr <= 32'h0;
            r_id_valid   <= 1'b0;
            r_id_pc      <= 32'h0;
            r_id_instr   <= RST_INSTR;
        end else if (redirect) begin
            // A fetch accepted in the redirect cycle is stale and must be drained in DROP.
            r_pc       <= w_redirect_pc;
            r_id_valid <= 1'b0;
            if (BUBBLE_EN) r_id_instr <= NOP_INSTR;
            case (r_state)
                S_REQ: begin
                    r_state    <= w_accept ? S_DROP : S_REQ;
                    r_imem_req <= ~w_accept;
                end
                S_WAIT, S_DROP: begin
                    r_state    <= imem_rvalid ? S_REQ : S_DROP;
                    r_imem_req <= imem_rvalid;
                end
                default: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
            endcase
        end else begin
            if (r_id_valid && !stall) begin
                r_id_valid <= 1'b0;
                if (BUBBLE_EN) r_id_instr <= NOP_INSTR;
            end
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (w_accept) begin
                        r_fetch_pc <= r_pc;
                        r_pc       <= r_pc + 32'd4;
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (w_load_ok) begin
                            r_id_valid <= 1'b1;
                            r_id_pc    <= r_fetch_pc;
                            r_id_instr <= imem_rdata;
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_skid_pc    <= r_fetch_pc;
                            r_skid_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_id_valid <= 1'b1;
                        r_id_pc    <= r_skid_pc;
                        r_id_instr <= r_skid_instr;
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_pc     = r_id_pc;
    assign id_instr  = r_id_instr;
    assign id_op     = r_id_instr[6:0];
    assign id_funct3 = r_id_instr[14:12];
    assign id_funct7 = r_id_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;
`ifdef FETCH_NOP_BUBBLE_EN
    localparam bit BUBBLE = 1'b1;
`else
    localparam bit BUBBLE = 1'b0;
`endif
    localparam logic [31:0] RST_INSTR = BUBBLE ? 32'h0000_0013 : 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req, imem_ready, imem_rvalid, stall, redirect, id_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_pc, id_instr;
    logic [6:0]  id_op, id_funct7;
    logic [2:0]  id_funct3;

    fetch_unit dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_op(id_op), .id_funct3(id_funct3), .id_funct7(id_funct7)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    // Reference: fetch stream as "next request", "one outstanding fetch (maybe stale)", skid queue, IF/ID.
    bit          m_started, m_req, m_out, m_stale, m_id_valid;
    logic [31:0] m_pc, m_fetch, m_id_pc, m_id_instr;
    logic [63:0] skid_q[$];
    logic [31:0] acc_q[$];

    // Memory: one pending response, delivered after a chosen latency.
    bit          pend;
    int          pcnt;
    logic [31:0] pdata;
    int          lat_lo = 1, lat_hi = 1;
    bit          data_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_req = 0; m_out = 0; m_stale = 0; m_id_valid = 0;
        m_pc = 32'h0; m_fetch = 32'h0; m_id_pc = 32'h0; m_id_instr = RST_INSTR;
        skid_q.delete(); acc_q.delete();
        pend = 0; pcnt = 0;
    endtask

    task automatic model_step();
        bit acc   = m_req && imem_ready;
        bit old_v = m_id_valid;
        if (acc) begin
            acc_q.push_back(m_pc);
            pend  = 1;
            pcnt  = $urandom_range(lat_hi, lat_lo) - 1;
            pdata = data_mode ? $urandom : m_pc + 32'h100;
        end
        if (!m_started) begin
            m_started = 1;
            m_req = 1;
            if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
        end else if (redirect) begin
            m_id_valid = 0;
            skid_q.delete();
            if (acc) begin m_out = 1; m_stale = 1; end
            else if (m_out && imem_rvalid) m_out = 0;
            else if (m_out) m_stale = 1;
            m_pc  = {redirect_pc[31:2], 2'b00};
            m_req = !m_out;
        end else begin
            if (old_v && !stall) m_id_valid = 0;
            if (acc) begin
                m_fetch = m_pc; m_pc = m_pc + 32'd4;
                m_out = 1; m_stale = 0; m_req = 0;
            end else if (m_out && imem_rvalid) begin
                m_out = 0;
                if (m_stale) m_req = 1;
                else if (!old_v || !stall) begin
                    m_id_valid = 1; m_id_pc = m_fetch; m_id_instr = imem_rdata; m_req = 1;
                end else begin
                    skid_q.push_back({m_fetch, imem_rdata}); m_req = 0;
                end
            end else if (skid_q.size() > 0 && !stall) begin
                {m_id_pc, m_id_instr} = skid_q.pop_front();
                m_id_valid = 1; m_req = 1;
            end
        end
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic cyc(input bit rdy, input bit stl, input bit rd, input logic [31:0] rpc);
        imem_ready = rdy; stall = stl; redirect = rd; redirect_pc = rpc;
        if (pend && pcnt == 0) begin
            imem_rvalid = 1; imem_rdata = pdata; pend = 0;
        end else begin
            imem_rvalid = 0; imem_rdata = $urandom;
            if (pend) pcnt--;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rstn = 0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, RST_INSTR);
        model_reset();
        imem_ready = 0; imem_rvalid = 0; stall = 0; redirect = 0;
        @(negedge clk);
        rstn = 1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0] e_instr;
            e_instr = (BUBBLE && !m_id_valid) ? 32'h0000_0013 : m_id_instr;
            chk("imem_req", imem_req, m_req);
            chk("imem_addr", imem_addr, m_pc);
            chk("id_valid", id_valid, m_id_valid);
            chk("id_pc", id_pc, m_id_pc);
            chk("id_instr", id_instr, e_instr);
            chk("id_op", id_op, e_instr[6:0]);
            chk("id_funct3", id_funct3, e_instr[14:12]);
            chk("id_funct7", id_funct7, e_instr[31:25]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] id_pcs[$];
        logic [31:0] id_ins[$];
        int vcnt, nacc, k;
        bit will, vseen;

        rstn = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_req", imem_req, 0);
        chk("init_addr", imem_addr, 32'h0);
        chk("init_valid", id_valid, 0);
        chk("init_instr", id_instr, RST_INSTR);
        chk_on = 1;
        rstn = 1;

        // Streaming, always-ready memory, 1-cycle latency, data = addr + 0x100.
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 0);
            if (m_id_valid) begin
                vcnt++; id_pcs.push_back(m_id_pc); id_ins.push_back(m_id_instr);
            end
        end
        chk("t1_acc0", acc_q[0], 32'h0);
        chk("t1_acc1", acc_q[1], 32'h4);
        chk("t1_acc2", acc_q[2], 32'h8);
        chk("t1_pc2", id_pcs[2], 32'h8);
        chk("t1_in0", id_ins[0], 32'h100);
        chk("t1_in2", id_ins[2], 32'h108);
        chk("t1_vcnt", vcnt, 5);

        // Stall while a response returns: parks in skid, no new request.
        cyc(1, 0, 0, 0);
        nacc = acc_q.size();
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        chk("t2_nacc", acc_q.size(), nacc + 1);
        chk("t2_req", m_req, 0);
        chk("t2_instr", m_id_instr, 32'h114);
        cyc(1, 0, 0, 0);
        chk("t2_skid_pc", m_id_pc, 32'h18);
        chk("t2_skid_in", m_id_instr, 32'h118);
        chk("t2_next", m_pc, 32'h1C);

        // Redirect while waiting; late response is dropped.
        lat_lo = 4; lat_hi = 4;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h8000_0002);
        chk("t3_addr", m_pc, 32'h8000_0000);
        chk("t3_req", m_req, 0);
        vseen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            vseen |= m_id_valid;
        end
        chk("t3_vseen", vseen, 0);
        chk("t3_acc", acc_q[acc_q.size()-1], 32'h8000_0000);

        // Redirect coinciding with the response under stall.
        lat_lo = 1; lat_hi = 1;
        k = 0; will = 0;
        while (!will && k < 10) begin
            will = pend && pcnt == 0;
            cyc(0, 1, will, 32'h0000_1003);
            k++;
        end
        chk("t4_hit", will, 1);
        chk("t4_valid", m_id_valid, 0);
        chk("t4_req", m_req, 1);
        chk("t4_addr", m_pc, 32'h0000_1000);

        // PC wrap.
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        chk("t5_addr", m_pc, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t5_wrap", m_pc, 32'h0);
        chk("t5_idpc", m_id_pc, 32'hFFFF_FFFC);
        chk("t5_in", m_id_instr, 32'h0000_00FC);

        // Reset mid-wait; stray response right after release is ignored.
        lat_lo = 3; lat_hi = 3;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        do_reset();
        lat_lo = 1; lat_hi = 1;
        pend = 1; pcnt = 0; pdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        chk("t6_acc", acc_q[0], 32'h0);
        chk("t6_idpc", m_id_pc, 32'h0);
        chk("t6_in", m_id_instr, 32'h100);

        // Randomized traffic.
        data_mode = 1; lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            else cyc($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3,
                     $urandom_range(99, 0) < 6, $urandom);
        end

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
